instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Inverse of the decode-side immediate generator: packs register/funct fields plus a signed
//  immediate into a 32-bit RV32I instruction word (R/I/S/B/U/J), range-checks the immediate,
//  tags each word with a sequential byte address, and buffers it in a small FIFO.
//  Sits between the test-program generator / boot loader and the instruction-memory writer.
// PARAMETERS
//  DEPTH      2          output FIFO entries (power of 2, >=2)
//  BASE_ADDR  32'h0      next-address value after reset (word aligned)
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   reset, asynchronous, active-low
//  in_valid    in   1   request valid
//  in_ready    out  1   request accepted when in_valid & in_ready at posedge
//  fmt         in   3   0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//  opcode      in   7   instr[6:0], copied verbatim
//  rd,rs1,rs2  in   5   register fields (ignored where format has none)
//  funct3      in   3   instr[14:12]; funct7 in 7: instr[31:25] (R only)
//  imm         in   32  signed immediate / byte offset (U: full value, low 12 bits zero)
//  addr_load   in   1   load next-address counter; addr_value in 32 = new address
//  out_valid   out  1   FIFO head valid
//  out_ready   in   1   pop head when out_valid & out_ready at posedge
//  out_instr   out  32  encoded word at head
//  out_addr    out  32  byte address of head word
//  out_err     out  1   head word had an illegal format or unrepresentable immediate
//  err_count   out  8   saturating count of errored words pushed
// BEHAVIOUR
//  - Reset (async assert, sync release): FIFO emptied, out_valid=0, out_instr/out_addr/out_err=0,
//    err_count=0, next_addr=BASE_ADDR. Reset mid-operation discards all queued entries.
//  - in_ready = !full (no pass-through when full, even if out_ready=1 that cycle).
//  - Push at edge N -> out_valid=1 from edge N (1-cycle latency); FIFO strictly in order.
//  - Simultaneous push+pop when neither full nor empty: occupancy unchanged; when empty, push only.
//  - Empty FIFO: out_instr, out_addr, out_err driven 0.
//  - Encoding (fields concatenated MSB..LSB):
//    R: funct7|rs2|rs1|funct3|rd|opcode      I: imm[11:0]|rs1|funct3|rd|opcode
//    S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
//    B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
//    U: imm[31:12]|rd|opcode                 J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
//  - Error rules (word still pushed, truncated bits encoded, out_err=1):
//    I,S: imm outside [-2048,2047]; B: outside [-4096,4094] or imm[0]=1;
//    J: outside [-1048576,1048574] or imm[0]=1; U: imm[11:0]!=0; fmt 6/7: instr=32'h0.
//  - err_count += 1 per errored push, saturates at 8'hFF; no wrap.
//  - Address: each push records out_addr=next_addr then next_addr+=4, wrapping mod 2^32.
//    addr_load alone: next_addr<=addr_value&~3. addr_load with push same edge: pushed word
//    gets addr_value&~3, next_addr<=(addr_value&~3)+4. Rejected request does not advance.
// TESTING
//  1 I: fmt=1 op=0010011 rd=1 rs1=0 f3=0 imm=5 -> out_instr 32'h00500093, out_addr BASE_ADDR, err 0
//  2 B/J/U: beq x1,x2,-8 -> 32'hFE208CE3; jal x1,2048 -> 32'h001000EF;
//    lui x5,imm=32'h12345000 -> 32'h123452B7; all out_err=0, addresses +4 apart
//  3 Errors: I imm=2048; B imm=3; U imm=32'h00000001; fmt=7 -> each out_err=1 (fmt 7 instr=0),
//    err_count=4; 260 errored pushes -> err_count holds 8'hFF
//  4 Backpressure DEPTH=2: out_ready=0, push A,B -> in_ready=0, C held on input unaccepted;
//    out_ready=1 -> A(BASE),B(BASE+4),C(BASE+8) in order, no loss or duplication
//  5 Address: addr_load=1 addr_value=32'h1003 with push -> out_addr 32'h1000, next 32'h1004;
//    load 32'hFFFFFFFC then two pushes -> out_addr 32'hFFFFFFFC, 32'h00000000
//  6 Reset mid-op: 2 entries queued, rst_n=0 between edges -> out_valid=0 immediately,
//    err_count=0; after release next push gets out_addr=BASE_ADDR

Source files
------------

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Packs register/funct fields and a signed immediate into a 32-bit RV32I
//   instruction word (R/I/S/B/U/J). The immediate is range-checked. Each word
//   is tagged with a sequential byte address and queued in a small output FIFO
//   that feeds the instruction-memory writer.
//
// Parameters
//   DEPTH      output FIFO entries (power of 2, >= 2)
//   BASE_ADDR  next-address value after reset (word aligned)
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid_i          request valid
//   in_ready_o          request accepted on in_valid_i & in_ready_o (= !full)
//   fmt_i               0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   opcode_i            instr[6:0]
//   rd_i/rs1_i/rs2_i    register fields
//   funct3_i/funct7_i   instr[14:12] / instr[31:25] (funct7 used by R only)
//   imm_i               signed immediate / byte offset
//   addr_load_i         load the address counter with addr_value_i & ~3
//   addr_value_i        new address
//   out_valid_o         FIFO head valid
//   out_ready_i         pop head on out_valid_o & out_ready_i
//   out_instr_o         encoded word at head (0 when empty)
//   out_addr_o          byte address of head word (0 when empty)
//   out_err_o           head word had illegal format / bad immediate
//   err_count_o         saturating count of errored words pushed
// ---------------------------------------------------------------------------
module instr_encoder #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  input  logic        addr_load_i,
  input  logic [31:0] addr_value_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_addr_o,
  output logic        out_err_o,
  output logic [7:0]  err_count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } entry_t;

  // -------------------------------------------------------------------------
  // Encoder (combinational)
  // -------------------------------------------------------------------------
  logic [31:0] enc_instr;
  logic        enc_err;

  // An immediate fits in N signed bits iff bits [31:N-1] are all equal.
  logic fits12, fits13, fits21;
  assign fits12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
  assign fits13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
  assign fits21 = (&imm_i[31:20]) | ~(|imm_i[31:20]);

  always_comb begin
    enc_instr = 32'h0;
    enc_err   = 1'b0;
    case (fmt_i)
      FMT_R: begin
        enc_instr = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      end
      FMT_I: begin
        enc_instr = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        enc_err   = ~fits12;
      end
      FMT_S: begin
        enc_instr = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        enc_err   = ~fits12;
      end
      FMT_B: begin
        enc_instr = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                     imm_i[4:1], imm_i[11], opcode_i};
        // 13-bit signed even offset: upper bound 4094 falls out of imm[0]==0
        enc_err   = ~fits13 | imm_i[0];
      end
      FMT_U: begin
        enc_instr = {imm_i[31:12], rd_i, opcode_i};
        enc_err   = |imm_i[11:0];
      end
      FMT_J: begin
        enc_instr = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                     rd_i, opcode_i};
        enc_err   = ~fits21 | imm_i[0];
      end
      default: begin
        // Illegal format: emit an all-zero word flagged as errored
        enc_instr = 32'h0;
        enc_err   = 1'b1;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FIFO control
  // -------------------------------------------------------------------------
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full, empty, push, pop;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  // No pass-through: a full FIFO refuses input even if it pops this cycle
  assign push  = in_valid_i & ~full;
  assign pop   = ~empty & out_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // -------------------------------------------------------------------------
  // Address counter and error counter
  // -------------------------------------------------------------------------
  logic [31:0] next_addr_q, next_addr_d;
  logic [31:0] addr_base;
  logic [7:0]  err_cnt_q, err_cnt_d;

  // A load on the same edge as a push applies to the pushed word itself
  assign addr_base = addr_load_i ? {addr_value_i[31:2], 2'b00} : next_addr_q;

  always_comb begin
    next_addr_d = addr_base;
    if (push) next_addr_d = addr_base + 32'd4;
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push && enc_err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      next_addr_q <= BASE_ADDR;
      err_cnt_q   <= 8'h0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      next_addr_q <= next_addr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Storage needs no reset: outputs are gated to zero while empty
  entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{instr: enc_instr, addr: addr_base, err: enc_err};
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  entry_t head;

  always_comb begin
    head = '0;
    if (!empty) head = mem_q[rd_ptr_q];
  end

  assign in_ready_o  = ~full;
  assign out_valid_o = ~empty;
  assign out_instr_o = head.instr;
  assign out_addr_o  = head.addr;
  assign out_err_o   = head.err;
  assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int          DEPTH = 2;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  fmt = '0;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;
  logic        addr_load = 1'b0;
  logic [31:0] addr_value = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .fmt_i(fmt), .opcode_i(opcode), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
    .funct3_i(funct3), .funct7_i(funct7), .imm_i(imm),
    .addr_load_i(addr_load), .addr_value_i(addr_value),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_instr_o(out_instr), .out_addr_o(out_addr), .out_err_o(out_err),
    .err_count_o(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_next;
  int          m_ecnt;

  function automatic void model_enc(input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im,
      output logic [31:0] w, output logic e);
    longint s;
    s = longint'($signed(im));
    w = 32'h0;
    e = 1'b0;
    case (f)
      3'd0: w = {f7, s2, s1, f3, d, op};
      3'd1: begin w = {im[11:0], s1, f3, d, op}; e = (s < -2048) || (s > 2047); end
      3'd2: begin w = {im[11:5], s2, s1, f3, im[4:0], op}; e = (s < -2048) || (s > 2047); end
      3'd3: begin
        w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
        e = (s < -4096) || (s > 4094) || (s % 2 != 0);
      end
      3'd4: begin w = {im[31:12], d, op}; e = (im % 4096) != 0; end
      3'd5: begin
        w = {im[20], im[10:1], im[11], im[19:12], d, op};
        e = (s < -1048576) || (s > 1048574) || (s % 2 != 0);
      end
      default: begin w = 32'h0; e = 1'b1; end
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_next = BASE;
      m_ecnt = 0;
    end else begin
      bit   do_push, do_pop;
      exp_t ent;
      logic [31:0] base;
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = (q.size() > 0) && out_ready;
      base = addr_load ? (addr_value / 4) * 4 : m_next;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        model_enc(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, ent.instr, ent.err);
        ent.addr = base;
        q.push_back(ent);
        if (ent.err && m_ecnt < 255) m_ecnt++;
        m_next = base + 32'd4;
      end else begin
        m_next = base;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < DEPTH});
      chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      chk("err_count", {24'b0, err_count}, m_ecnt);
      if (q.size() != 0) begin
        chk("head_instr", out_instr, q[0].instr);
        chk("head_addr", out_addr, q[0].addr);
        chk("head_err", {31'b0, out_err}, {31'b0, q[0].err});
      end else begin
        chk("empty_instr", out_instr, 32'h0);
        chk("empty_addr", out_addr, 32'h0);
        chk("empty_err", {31'b0, out_err}, 32'h0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
      input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = 7'h00;
    imm = im; in_valid = 1'b1;
  endtask

  // Hold the request until accepted; returns at the negedge after acceptance.
  task automatic wait_accept();
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      acc = in_ready;
      @(negedge clk);
      if (acc) break;
    end
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout: request never accepted");
    end
    in_valid = 1'b0;
    addr_load = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (DEPTH + 1) @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    logic        e;

    // Pin the model with hand-computed encodings
    model_enc(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, w, e);
    chk("model_addi", w, 32'h00500093);
    model_enc(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd8, w, e);
    chk("model_beq", w, 32'hFE208CE3);
    model_enc(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, w, e);
    chk("model_b_odd_err", {31'b0, e}, 32'h1);

    // Reset state
    #3;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_addr", out_addr, 32'h0);
    chk("rst_err_count", {24'b0, err_count}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: addi x1,x0,5
    set_req(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    wait_accept();
    chk("t1_instr", out_instr, 32'h00500093);
    chk("t1_addr", out_addr, BASE);
    chk("t1_err", {31'b0, out_err}, 32'h0);
    drain();

    // 2: B/J/U streaming
    out_ready = 1'b1;
    set_req(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd8);
    wait_accept();
    chk("t2_beq", out_instr, 32'hFE208CE3);
    chk("t2_beq_addr", out_addr, BASE + 32'd4);
    set_req(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
    wait_accept();
    chk("t2_jal", out_instr, 32'h001000EF);
    chk("t2_jal_addr", out_addr, BASE + 32'd8);
    set_req(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000);
    wait_accept();
    chk("t2_lui", out_instr, 32'h123452B7);
    chk("t2_lui_addr", out_addr, BASE + 32'd12);
    chk("t2_lui_err", {31'b0, out_err}, 32'h0);

    // 3: errors
    set_req(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
    wait_accept();
    chk("t3_i_err", {31'b0, out_err}, 32'h1);
    set_req(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3);
    wait_accept();
    chk("t3_b_err", {31'b0, out_err}, 32'h1);
    set_req(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1);
    wait_accept();
    chk("t3_u_err", {31'b0, out_err}, 32'h1);
    set_req(3'd7, 7'b0110011, 5'd3, 5'd4, 5'd5, 3'd0, 32'h0);
    wait_accept();
    chk("t3_f7_err", {31'b0, out_err}, 32'h1);
    chk("t3_f7_instr", out_instr, 32'h0);
    chk("t3_err_count4", {24'b0, err_count}, 32'd4);
    // Edge values that must be accepted without error
    set_req(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, -32'sd2048);
    wait_accept();
    chk("t3_s_min_ok", {31'b0, out_err}, 32'h0);
    set_req(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd4094);
    wait_accept();
    chk("t3_b_max_ok", {31'b0, out_err}, 32'h0);
    set_req(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1048576);
    wait_accept();
    chk("t3_j_over_err", {31'b0, out_err}, 32'h1);
    for (int i = 0; i < 260; i++) begin
      set_req(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0);
      wait_accept();
    end
    drain();
    chk("t3_err_sat", {24'b0, err_count}, 32'hFF);

    // 4: backpressure
    do_reset();
    out_ready = 1'b0;
    set_req(3'd0, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 32'h0);   // A
    wait_accept();
    set_req(3'd0, 7'b0110011, 5'd4, 5'd5, 5'd6, 3'd0, 32'h0);   // B
    wait_accept();
    set_req(3'd0, 7'b0110011, 5'd7, 5'd8, 5'd9, 3'd0, 32'h0);   // C held
    repeat (3) begin
      @(negedge clk);
      chk("t4_in_ready_low", {31'b0, in_ready}, 32'h0);
    end
    chk("t4_head_A", out_instr, 32'h003100B3);
    chk("t4_head_A_addr", out_addr, BASE);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_head_B_addr", out_addr, BASE + 32'd4);
    chk("t4_head_B", out_instr, 32'h00628233);
    wait_accept();
    chk("t4_head_C_addr", out_addr, BASE + 32'd8);
    chk("t4_head_C", out_instr, 32'h009403B3);
    @(negedge clk);
    chk("t4_empty", {31'b0, out_valid}, 32'h0);
    out_ready = 1'b0;

    // 5: address load
    set_req(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
    addr_load = 1'b1; addr_value = 32'h1003;
    wait_accept();
    chk("t5_load_push_addr", out_addr, 32'h1000);
    drain();
    set_req(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2);
    wait_accept();
    chk("t5_next_addr", out_addr, 32'h1004);
    drain();
    addr_load = 1'b1; addr_value = 32'hFFFFFFFC;
    @(negedge clk);
    addr_load = 1'b0;
    out_ready = 1'b1;
    set_req(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3);
    wait_accept();
    chk("t5_top_addr", out_addr, 32'hFFFFFFFC);
    set_req(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd4);
    wait_accept();
    chk("t5_wrap_addr", out_addr, 32'h0);
    drain();

    // 6: reset mid-operation
    set_req(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5000);  // errored
    wait_accept();
    set_req(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd6);
    wait_accept();
    chk("t6_err_before", {24'b0, err_count}, 32'd1);
    chk("t6_valid_before", {31'b0, out_valid}, 32'h1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("t6_rst_err_count", {24'b0, err_count}, 32'h0);
    chk("t6_rst_instr", out_instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    set_req(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd7);
    wait_accept();
    chk("t6_post_addr", out_addr, BASE);
    chk("t6_post_instr", out_instr, 32'h00700093);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
